// File: rtl/seg7_display_driver_pkg.sv
// Shared definitions for the 7-segment display driver: converter FSM states,
// segment patterns (active-high, bit order {g,f,e,d,c,b,a}) and the nibble decoder.
package seg7_display_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Non-decimal nibbles show a dash so a corrupted BCD value is visible on the board.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_display_driver_bin8_to_bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to 3-digit BCD in 10 cycles.
// Interface: no handshake. A new conversion starts whenever bin differs from the
// last captured value while idle; changes during a conversion are not captured
// (the newest value is picked up on return to IDLE). busy is high while not IDLE;
// done pulses for one cycle in the cycle bcd first shows the new value.
module bin8_to_bcd_seq
  import seg7_display_driver_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        busy,
  output logic        done
);

  conv_state_t state, state_nxt;
  logic [19:0] shift_reg;
  logic [19:0] adj;
  logic [2:0]  iter;
  logic [7:0]  last_val;

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: capture on change, eight shifts, one cycle to publish.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bin != last_val) state_nxt = SHIFT;
      SHIFT:   if (iter == 3'd7)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble that would overflow past 9 after doubling.
  always_comb begin
    adj = shift_reg;
    if (adj[11:8]  >= 4'd5) adj[11:8]  = adj[11:8]  + 4'd3;
    if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
    if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
  end

  // Datapath: capture, shift, publish; done is registered off the DONE state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      iter      <= '0;
      last_val  <= '0;
      bcd       <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (bin != last_val) begin
            shift_reg <= {12'h000, bin};
            last_val  <= bin;
            iter      <= '0;
          end
        end
        SHIFT: begin
          shift_reg <= {adj[18:0], 1'b0};
          iter      <= iter + 3'd1;
        end
        DONE:    bcd <= shift_reg[19:8];
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/seg7_display_driver.sv
// 3-digit multiplexed 7-segment driver for the 8-bit parallel output port.
// Holds the refresh prescaler, digit scan, segment decode, leading-zero blanking
// and the registered seg/an outputs; conversion is done by bin8_to_bcd_seq.
module seg7_display_driver
  import seg7_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] bcd,
  output logic        busy,
  output logic        conv_done
);

  localparam int         PW      = $clog2(REFRESH_DIV);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_OFF  = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;

  logic [PW-1:0] prescaler;
  logic [1:0]    digit_sel;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg_pat;
  logic [2:0]    an_pat;

  bin8_to_bcd_seq u_conv (
    .clk  (clk),
    .rst  (rst),
    .bin  (data_in),
    .bcd  (bcd),
    .busy (busy),
    .done (conv_done)
  );

  // Refresh prescaler and digit scan; an out-of-range digit_sel recovers to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      digit_sel <= 2'd0;
    end else begin
      if (prescaler == PW'(REFRESH_DIV - 1)) prescaler <= '0;
      else                                   prescaler <= prescaler + PW'(1);
      if (digit_sel == 2'd3) begin
        digit_sel <= 2'd0;
      end else if (prescaler == PW'(REFRESH_DIV - 1)) begin
        digit_sel <= (digit_sel == 2'd2) ? 2'd0 : digit_sel + 2'd1;
      end
    end
  end

  // Select the nibble for the current slot and decide whether it is a leading zero.
  always_comb begin
    nib    = bcd[3:0];
    blank  = 1'b0;
    an_pat = 3'b001;
    case (digit_sel)
      2'd1: begin
        nib    = bcd[7:4];
        blank  = BLANK_LEADING && (bcd[11:4] == 8'h00);
        an_pat = 3'b010;
      end
      2'd2: begin
        nib    = bcd[11:8];
        blank  = BLANK_LEADING && (bcd[11:8] == 4'h0);
        an_pat = 3'b100;
      end
      default: ;
    endcase
    seg_pat = blank ? 7'h00 : seg_decode(nib);
  end

  // Output registers; polarity is applied here so the outputs are glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= SEG_ACTIVE_LOW ? ~seg_pat : seg_pat;
      an  <= SEG_ACTIVE_LOW ? ~an_pat  : an_pat;
    end
  end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Directed bench for seg7_display_driver (REFRESH_DIV=4, active-high, blanking on).
module tb_seg7_display_driver;

  logic        clk;
  logic        rst;
  logic [7:0]  data_in;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic [11:0] bcd;
  logic        busy;
  logic        conv_done;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int d0;
  bit ok;

  seg7_display_driver #(
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1'b0),
    .BLANK_LEADING  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .seg       (seg),
    .an        (an),
    .bcd       (bcd),
    .busy      (busy),
    .conv_done (conv_done)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count conv_done pulses, sampled away from the active edge
  always @(negedge clk) if (conv_done === 1'b1) done_cnt++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance to the first cycle of a units slot (an just became 001), bounded
  task automatic sync_units(output bit found);
    logic [2:0] prev;
    int i;
    found = 1'b0;
    prev  = an;
    i     = 0;
    while (!found && i < 24) begin
      tick(1);
      if (an == 3'b001 && prev != 3'b001) found = 1'b1;
      prev = an;
      i++;
    end
  endtask

  initial begin
    // 1: reset with data_in=0
    rst     = 1'b0;
    data_in = 8'd0;
    tick(3);
    check("rst_bcd",  32'(bcd), 32'h000);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(conv_done), 32'd0);
    check("rst_an",   32'(an), 32'b000);
    check("rst_seg",  32'(seg), 32'h00);
    rst = 1'b1;
    tick(1);
    check("t1_an_u",  32'(an), 32'b001);
    check("t1_seg_u", 32'(seg), 32'h3F);
    tick(4);
    check("t1_an_t",  32'(an), 32'b010);
    check("t1_seg_t", 32'(seg), 32'h00);
    tick(4);
    check("t1_an_h",  32'(an), 32'b100);
    check("t1_seg_h", 32'(seg), 32'h00);
    check("t1_busy",  32'(busy), 32'd0);
    check("t1_ndone", 32'(done_cnt), 32'd0);

    // 2: 255, busy next edge, bcd on the 10th edge
    data_in = 8'd255;
    tick(1);
    check("t2_busy_rise", 32'(busy), 32'd1);
    tick(8);
    check("t2_bcd_early", 32'(bcd), 32'h000);
    check("t2_busy_mid",  32'(busy), 32'd1);
    check("t2_done_early", 32'(conv_done), 32'd0);
    tick(1);
    check("t2_bcd",  32'(bcd), 32'h255);
    check("t2_done", 32'(conv_done), 32'd1);
    check("t2_busy_fall", 32'(busy), 32'd0);
    tick(1);
    check("t2_done_1cyc", 32'(conv_done), 32'd0);

    // 3: 7, scan slots of 4 cycles
    data_in = 8'd7;
    tick(10);
    check("t3_bcd", 32'(bcd), 32'h007);
    sync_units(ok);
    check("t3_sync", 32'(ok), 32'd1);
    check("t3_seg_u", 32'(seg), 32'h07);
    tick(3);
    check("t3_an_u_hold", 32'(an), 32'b001);
    tick(1);
    check("t3_an_t",  32'(an), 32'b010);
    check("t3_seg_t", 32'(seg), 32'h00);
    tick(4);
    check("t3_an_h",  32'(an), 32'b100);
    check("t3_seg_h", 32'(seg), 32'h00);
    tick(4);
    check("t3_an_wrap", 32'(an), 32'b001);
    check("t3_seg_wrap", 32'(seg), 32'h07);

    // 4: 100 then 42 while busy
    data_in = 8'd100;
    tick(1);
    check("t4_busy", 32'(busy), 32'd1);
    tick(2);
    data_in = 8'd42;
    tick(7);
    check("t4_bcd1",  32'(bcd), 32'h100);
    check("t4_done1", 32'(conv_done), 32'd1);
    tick(1);
    check("t4_busy2", 32'(busy), 32'd1);
    check("t4_done_low", 32'(conv_done), 32'd0);
    tick(9);
    check("t4_bcd2",  32'(bcd), 32'h042);
    check("t4_done2", 32'(conv_done), 32'd1);

    // 5: reset mid-conversion
    tick(2);
    data_in = 8'd200;
    tick(4);
    check("t5_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_rst_bcd",  32'(bcd), 32'h000);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_an",   32'(an), 32'b000);
    tick(2);
    rst = 1'b1;
    tick(9);
    check("t5_bcd_early", 32'(bcd), 32'h000);
    check("t5_busy_conv", 32'(busy), 32'd1);
    tick(1);
    check("t5_bcd",  32'(bcd), 32'h200);
    check("t5_done", 32'(conv_done), 32'd1);

    // 6: 89 held, one conversion, full rotation
    tick(2);
    d0 = done_cnt;
    data_in = 8'd89;
    tick(10);
    check("t6_bcd", 32'(bcd), 32'h089);
    sync_units(ok);
    check("t6_sync", 32'(ok), 32'd1);
    check("t6_seg_u", 32'(seg), 32'h6F);
    tick(4);
    check("t6_an_t",  32'(an), 32'b010);
    check("t6_seg_t", 32'(seg), 32'h7F);
    tick(4);
    check("t6_an_h",  32'(an), 32'b100);
    check("t6_seg_h", 32'(seg), 32'h00);
    tick(4);
    check("t6_an_u",  32'(an), 32'b001);
    tick(2);
    check("t6_one_done", 32'(done_cnt - d0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
